atm_session_ctrl: RTL and testbench
===================================

ATM_SESSION_CTRL -- requirements
Module: atm_session_ctrl

Interface
REQ-001 Parameter MAX_TRIES, default 3: consecutive wrong-PIN authentications that trigger lockout.
REQ-002 Parameter TIMEOUT_CYCLES, default 100: idle MENU cycles before forced logout.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 card_in  in  1  card present; level, held for the whole session.
REQ-006 acc_number  in  12  account number, sampled with pin at auth request.
REQ-007 pin  in  4  PIN, sampled with acc_number.
REQ-008 op_valid  in  1  one-cycle user request strobe for menu_option.
REQ-009 menu_option  in  3  3 balance, 4 withdraw, 5 withdraw+show, 6 transfer, 7 deposit.
REQ-010 amount  in  11  operation amount; dest_acc  in  12  transfer destination.
REQ-011 dp_ack  in  1  datapath completion pulse; dp_status  in  2  0 ok, 1 insufficient funds, 2 bad account/dest, 3 bad PIN; valid with dp_ack.
REQ-012 dp_req  out  1  datapath request; dp_cmd  out  3  1 authenticate, else menu code.
REQ-013 dp_acc, dp_dest  out  12 each; dp_amount  out  11; dp_pin  out  4: latched operands.
REQ-014 session_active  out  1; locked  out  1; busy  out  1 (dp_req outstanding).
REQ-015 done  out  1  one-cycle pulse per completed op; last_status  out  2  held status.
REQ-016 timeout_evt  out  1  one-cycle pulse; err_invalid  out  1  one-cycle pulse.

Function
REQ-017 States IDLE, AUTH_WAIT, MENU, EXEC_WAIT, LOCKED; encoding free.
REQ-018 IDLE: on card_in=1, latch acc_number/pin into dp_acc/dp_pin, dp_cmd=1, dp_req=1, go AUTH_WAIT next cycle.
REQ-019 dp_req and all dp_* operands held stable from assertion until the cycle dp_ack is sampled 1; dp_req low the following cycle.
REQ-020 dp_ack while dp_req=0 ignored, no state or output change.
REQ-021 AUTH_WAIT, ack status 0: fail_cnt cleared, session_active=1, go MENU.
REQ-022 AUTH_WAIT, ack status 2 or 3: fail_cnt+1; if new count = MAX_TRIES go LOCKED, else go IDLE.
REQ-023 IDLE after a failure waits for card_in=0 for at least one cycle before a new auth (no retry loop on held card).
REQ-024 LOCKED: locked=1, no dp_req issued; exit to IDLE on first cycle card_in=0, clearing fail_cnt.
REQ-025 MENU: op_valid with code 3..7 latches amount/dest_acc, dp_cmd=code, dp_req=1, go EXEC_WAIT next cycle.
REQ-026 MENU: op_valid with code 0..2 -> err_invalid pulse next cycle, stay MENU, idle counter not cleared.
REQ-027 EXEC_WAIT: op_valid ignored; on dp_ack, last_status=dp_status, done pulse same cycle state returns MENU.
REQ-028 Idle counter counts MENU cycles without accepted op; cleared on accepted op and on MENU entry; saturates never past TIMEOUT_CYCLES.
REQ-029 Counter reaching TIMEOUT_CYCLES -> timeout_evt pulse, session_active=0, go IDLE (card removal then required per REQ-023).
REQ-030 card_in=0 in MENU -> IDLE next cycle, session_active=0, no timeout_evt.
REQ-031 card_in=0 in AUTH_WAIT or EXEC_WAIT: outstanding request completes first, then IDLE; result still reported (done/last_status for ops).
REQ-032 Simultaneous timeout and op_valid: op accepted, counter cleared, no timeout_evt.
REQ-033 busy=dp_req; fail_cnt width clog2(MAX_TRIES)+1, never exceeds MAX_TRIES.

Reset
REQ-034 rst_n=0 immediately: state IDLE, fail_cnt 0, idle counter 0, all outputs 0, last_status 0.
REQ-035 Reset mid-request drops dp_req at once; a later dp_ack is ignored per REQ-020.

Verification
REQ-036 card_in=1, acc 2816 pin 6, ack status 0 -> dp_req one handshake with dp_cmd=1, session_active=1 in MENU.
REQ-037 Three wrong-PIN auths (status 3), card toggled between -> locked=1 after third; card_in=0 -> locked=0, fail_cnt 0.
REQ-038 MENU, op_valid code 4 amount 505, ack status 1 -> done pulse, last_status=1, back in MENU; code 2 -> err_invalid only.
REQ-039 MENU idle 100 cycles -> timeout_evt on 100th, session_active=0; op at cycle 100 -> no timeout.
REQ-040 Transfer code 6 dest 3467 amount 99, card_in=0 before ack -> dp_operands stable, done reported, then IDLE.
REQ-041 rst_n low during EXEC_WAIT then stray dp_ack -> outputs stay 0, state IDLE.

Source files
------------

// File: rtl/atm_session_ctrl.sv
// rtl/atm_session_ctrl.sv - ATM session sequencer: card auth, menu ops, lockout and idle timeout
module atm_session_ctrl #(
    parameter int MAX_TRIES      = 3,
    parameter int TIMEOUT_CYCLES = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        card_in,
    input  logic [11:0] acc_number,
    input  logic [3:0]  pin,
    input  logic        op_valid,
    input  logic [2:0]  menu_option,
    input  logic [10:0] amount,
    input  logic [11:0] dest_acc,
    input  logic        dp_ack,
    input  logic [1:0]  dp_status,
    output logic        dp_req,
    output logic [2:0]  dp_cmd,
    output logic [11:0] dp_acc,
    output logic [11:0] dp_dest,
    output logic [10:0] dp_amount,
    output logic [3:0]  dp_pin,
    output logic        session_active,
    output logic        locked,
    output logic        busy,
    output logic        done,
    output logic [1:0]  last_status,
    output logic        timeout_evt,
    output logic        err_invalid
);
    localparam int FW = $clog2(MAX_TRIES) + 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_TRIES);
    localparam logic [CW-1:0] IDLE_LAST  = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_AUTH_WAIT = 3'd1;
    localparam logic [2:0] S_MENU      = 3'd2;
    localparam logic [2:0] S_EXEC_WAIT = 3'd3;
    localparam logic [2:0] S_LOCKED    = 3'd4;

    logic [2:0]    state;
    logic [FW-1:0] fail_cnt;
    logic [FW-1:0] fail_next;
    logic [CW-1:0] idle_cnt;
    // Set whenever a session ends so a still-inserted card cannot re-authenticate.
    logic          need_removal;

    assign fail_next = fail_cnt + FW'(1);
    assign busy      = dp_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            fail_cnt       <= '0;
            idle_cnt       <= '0;
            need_removal   <= 1'b0;
            dp_req         <= 1'b0;
            dp_cmd         <= '0;
            dp_acc         <= '0;
            dp_dest        <= '0;
            dp_amount      <= '0;
            dp_pin         <= '0;
            session_active <= 1'b0;
            locked         <= 1'b0;
            done           <= 1'b0;
            last_status    <= '0;
            timeout_evt    <= 1'b0;
            err_invalid    <= 1'b0;
        end else begin
            done        <= 1'b0;
            timeout_evt <= 1'b0;
            err_invalid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!card_in) begin
                        need_removal <= 1'b0;
                    end else if (!need_removal) begin
                        dp_acc <= acc_number;
                        dp_pin <= pin;
                        dp_cmd <= 3'd1;
                        dp_req <= 1'b1;
                        state  <= S_AUTH_WAIT;
                    end
                end
                S_AUTH_WAIT: begin
                    if (dp_ack) begin
                        dp_req       <= 1'b0;
                        need_removal <= 1'b1;
                        if (dp_status == 2'd0) begin
                            fail_cnt <= '0;
                            if (card_in) begin
                                session_active <= 1'b1;
                                idle_cnt       <= '0;
                                state          <= S_MENU;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else if (dp_status[1]) begin
                            fail_cnt <= fail_next;
                            if (fail_next == FAIL_LIMIT) begin
                                locked <= 1'b1;
                                state  <= S_LOCKED;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_MENU: begin
                    // Card removal wins over a same-cycle request; an accepted op wins over timeout.
                    if (!card_in) begin
                        session_active <= 1'b0;
                        need_removal   <= 1'b1;
                        state          <= S_IDLE;
                    end else if (op_valid && menu_option >= 3'd3) begin
                        dp_cmd    <= menu_option;
                        dp_amount <= amount;
                        dp_dest   <= dest_acc;
                        dp_req    <= 1'b1;
                        idle_cnt  <= '0;
                        state     <= S_EXEC_WAIT;
                    end else begin
                        if (op_valid) begin
                            err_invalid <= 1'b1;
                        end
                        if (idle_cnt == IDLE_LAST) begin
                            timeout_evt    <= 1'b1;
                            session_active <= 1'b0;
                            need_removal   <= 1'b1;
                            idle_cnt       <= '0;
                            state          <= S_IDLE;
                        end else begin
                            idle_cnt <= idle_cnt + CW'(1);
                        end
                    end
                end
                S_EXEC_WAIT: begin
                    if (dp_ack) begin
                        dp_req      <= 1'b0;
                        last_status <= dp_status;
                        done        <= 1'b1;
                        idle_cnt    <= '0;
                        if (card_in) begin
                            state <= S_MENU;
                        end else begin
                            session_active <= 1'b0;
                            need_removal   <= 1'b1;
                            state          <= S_IDLE;
                        end
                    end
                end
                S_LOCKED: begin
                    if (!card_in) begin
                        locked       <= 1'b0;
                        fail_cnt     <= '0;
                        need_removal <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb/tb_atm_session_ctrl.sv - scoreboard bench for atm_session_ctrl
module tb_atm_session_ctrl;
    localparam int K_AUTH = 0;
    localparam int K_OP   = 1;
    localparam int K_DONE = 2;
    localparam int K_ERR  = 3;
    localparam int K_TO   = 4;

    logic        clk = 1'b0;
    logic        rst_n, card_in, op_valid, dp_ack;
    logic [11:0] acc_number, dest_acc;
    logic [3:0]  pin;
    logic [2:0]  menu_option;
    logic [10:0] amount;
    logic [1:0]  dp_status;
    logic        dp_req, session_active, locked, busy, done, timeout_evt, err_invalid;
    logic [2:0]  dp_cmd;
    logic [11:0] dp_acc, dp_dest;
    logic [10:0] dp_amount;
    logic [3:0]  dp_pin;
    logic [1:0]  last_status;

    atm_session_ctrl #(.MAX_TRIES(3), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n), .card_in(card_in), .acc_number(acc_number), .pin(pin),
        .op_valid(op_valid), .menu_option(menu_option), .amount(amount), .dest_acc(dest_acc),
        .dp_ack(dp_ack), .dp_status(dp_status), .dp_req(dp_req), .dp_cmd(dp_cmd),
        .dp_acc(dp_acc), .dp_dest(dp_dest), .dp_amount(dp_amount), .dp_pin(dp_pin),
        .session_active(session_active), .locked(locked), .busy(busy), .done(done),
        .last_status(last_status), .timeout_evt(timeout_evt), .err_invalid(err_invalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int cmd;
        int a;
        int b;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int cmd, input int a, input int b);
        exp_t e;
        e.kind = kind; e.cmd = cmd; e.a = a; e.b = b;
        sb.push_back(e);
    endtask

    task automatic check_event(input int kind);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got event kind %0d expected none at %0t", kind, $time);
            return;
        end
        e = sb.pop_front();
        if (e.kind != kind) begin
            errors++;
            $display("FAIL sb_kind: got event kind %0d expected kind %0d at %0t", kind, e.kind, $time);
            return;
        end
        case (kind)
            K_AUTH: begin
                chk("auth_acc", dp_acc, e.a);
                chk("auth_pin", dp_pin, e.b);
            end
            K_OP: begin
                chk("op_cmd", dp_cmd, e.cmd);
                chk("op_amount", dp_amount, e.a);
                chk("op_dest", dp_dest, e.b);
            end
            K_DONE: chk("done_status", last_status, e.a);
            default: ;
        endcase
    endtask

    // Monitor: consumes scoreboard entries on DUT-presented events and checks operand stability.
    logic        req_prev = 1'b0;
    logic [41:0] cap;
    always @(negedge clk) begin
        if (dp_req && !req_prev) begin
            check_event((dp_cmd == 3'd1) ? K_AUTH : K_OP);
            cap = {dp_cmd, dp_acc, dp_dest, dp_amount, dp_pin};
        end else if (dp_req) begin
            checks++;
            if ({dp_cmd, dp_acc, dp_dest, dp_amount, dp_pin} !== cap) begin
                errors++;
                $display("FAIL operands_stable: got %h expected %h", {dp_cmd, dp_acc, dp_dest, dp_amount, dp_pin}, cap);
            end
        end
        if (done)        check_event(K_DONE);
        if (err_invalid) check_event(K_ERR);
        if (timeout_evt) check_event(K_TO);
        req_prev = dp_req;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ack(input int st);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!dp_req && k < 50);
        if (!dp_req) chk("ack_wait_req", dp_req, 1);
        dp_ack = 1'b1;
        dp_status = 2'(st);
        @(posedge clk);
        #1;
        dp_ack = 1'b0;
        chk("req_drop_after_ack", dp_req, 0);
        chk("busy_after_ack", busy, 0);
    endtask

    task automatic op(input int code, input int amt, input int dst);
        op_valid = 1'b1;
        menu_option = 3'(code);
        amount = 11'(amt);
        dest_acc = 12'(dst);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; card_in = 1'b0; op_valid = 1'b0; dp_ack = 1'b0; dp_status = '0;
        acc_number = '0; pin = '0; menu_option = '0; amount = '0; dest_acc = '0;
        cyc(2);
        chk("rst_dp_req", dp_req, 0);
        chk("rst_session", session_active, 0);
        chk("rst_locked", locked, 0);
        chk("rst_done", done, 0);
        chk("rst_last_status", last_status, 0);
        chk("rst_timeout", timeout_evt, 0);
        chk("rst_err", err_invalid, 0);
        chk("rst_dp_cmd", dp_cmd, 0);
        rst_n = 1'b1;
        cyc(1);

        // Successful authentication
        acc_number = 12'd2816; pin = 4'd6; card_in = 1'b1;
        push(K_AUTH, 1, 2816, 6);
        ack(0);
        chk("auth_session", session_active, 1);
        chk("auth_locked", locked, 0);

        // Withdraw with insufficient funds, then an invalid code
        push(K_OP, 4, 505, 0); push(K_DONE, 0, 1, 0);
        op(4, 505, 0);
        ack(1);
        chk("withdraw_status", last_status, 1);
        chk("withdraw_session", session_active, 1);
        push(K_ERR, 0, 0, 0);
        op(2, 0, 0);
        cyc(2);
        chk("invalid_session", session_active, 1);

        // Idle timeout on the 100th menu cycle
        push(K_OP, 3, 0, 0); push(K_DONE, 0, 0, 0); push(K_TO, 0, 0, 0);
        op(3, 0, 0);
        ack(0);
        cyc(99);
        chk("timeout_not_early", timeout_evt, 0);
        chk("session_before_timeout", session_active, 1);
        cyc(1);
        chk("timeout_pulse", timeout_evt, 1);
        chk("timeout_session", session_active, 0);
        cyc(3);
        card_in = 1'b0;
        cyc(1);
        card_in = 1'b1;
        push(K_AUTH, 1, 2816, 6);
        ack(0);

        // Op on the 100th cycle beats the timeout
        cyc(99);
        push(K_OP, 7, 12, 5); push(K_DONE, 0, 0, 0);
        op(7, 12, 5);
        chk("op_beats_timeout", timeout_evt, 0);
        chk("op_beats_session", session_active, 1);
        ack(0);

        // Transfer with card pulled before the ack
        push(K_OP, 6, 99, 3467); push(K_DONE, 0, 2, 0);
        op(6, 99, 3467);
        amount = '0; dest_acc = '0; menu_option = '0;
        cyc(2);
        card_in = 1'b0;
        cyc(3);
        ack(2);
        chk("transfer_session", session_active, 0);
        chk("transfer_status", last_status, 2);
        cyc(3);
        chk("transfer_idle_req", dp_req, 0);

        // Lockout after three wrong PINs, twice, proving the counter clears on exit
        acc_number = 12'd1234; pin = 4'd9;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                card_in = 1'b1;
                push(K_AUTH, 1, 1234, 9);
                ack(3);
                cyc(2);
                chk("locked_after_try", locked, (i == 2) ? 1 : 0);
                chk("session_after_try", session_active, 0);
                card_in = 1'b0;
                cyc(1);
                chk("locked_after_removal", locked, 0);
            end
        end

        // Reset during an operation, then a stray ack
        acc_number = 12'd2816; pin = 4'd6; card_in = 1'b1;
        push(K_AUTH, 1, 2816, 6);
        ack(0);
        push(K_OP, 5, 7, 1);
        op(5, 7, 1);
        cyc(2);
        rst_n = 1'b0;
        #1;
        chk("midrst_dp_req", dp_req, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_session", session_active, 0);
        chk("midrst_last_status", last_status, 0);
        chk("midrst_dp_cmd", dp_cmd, 0);
        chk("midrst_dp_amount", dp_amount, 0);
        card_in = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        @(negedge clk);
        dp_ack = 1'b1; dp_status = 2'd0;
        @(posedge clk);
        #1;
        dp_ack = 1'b0;
        chk("stray_dp_req", dp_req, 0);
        chk("stray_done", done, 0);
        chk("stray_session", session_active, 0);
        chk("stray_last_status", last_status, 0);
        cyc(3);

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
